// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   localparam int LATENCY_MAX = 15;
   localparam int CNT_BITS    = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed single-port RAM with byte-enable writes and a registered read port.
module dmem_array #(
   parameter int IDX_BITS = 10
) (
   input  logic                clk,
   input  logic                en_i,
   input  logic                we_i,
   input  logic [3:0]          be_i,
   input  logic [IDX_BITS-1:0] idx_i,
   input  logic [31:0]         wdata_i,
   output logic [31:0]         rdata_o
);

   logic [31:0] mem_q [2**IDX_BITS];
   logic [31:0] rdata_q;

   // Contents are deliberately never reset so they survive a responder reset.
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            for (int b = 0; b < 4; b++) begin
               if (be_i[b]) begin
                  mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
               end
            end
         end else begin
            rdata_q <= mem_q[idx_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one outstanding word request, serviced from dmem_array after LATENCY cycles.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 4
) (
   input  logic        clk,
   input  logic        rst,
   // Both channels: a transfer happens on a rising edge where valid && ready.
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output state_t      dbg_state
);

   localparam int                  IDX_BITS = ADDR_WIDTH - 2;
   localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

   state_t              state_q;
   logic [CNT_BITS-1:0] cnt_q;
   logic                we_q;
   logic [31:0]         addr_q;
   logic [31:0]         wdata_q;
   logic [3:0]          be_q;
   logic                req_ready_q;
   logic                resp_valid_q;
   logic                resp_err_q;
   logic                rd_sel_q;

   logic                addr_err;
   logic                commit;
   logic                arr_en;
   logic [31:0]         arr_rdata;

   assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_WIDTH] != '0);
   // The commit edge is the last WAIT cycle; a coincident reset cancels it.
   assign commit   = (state_q == WAIT) && (cnt_q == '0) && !rst;
   assign arr_en   = commit && !addr_err;

   dmem_array #(.IDX_BITS(IDX_BITS)) u_array (
      .clk     (clk),
      .en_i    (arr_en),
      .we_i    (we_q),
      .be_i    (be_q),
      .idx_i   (addr_q[ADDR_WIDTH-1:2]),
      .wdata_i (wdata_q),
      .rdata_o (arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         rd_sel_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q        <= req_we;
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  be_q        <= req_be;
                  cnt_q       <= CNT_LOAD;
                  req_ready_q <= 1'b0;
                  state_q     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= addr_err;
                  rd_sel_q     <= !addr_err && !we_q;
                  state_q      <= RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  resp_err_q   <= 1'b0;
                  rd_sel_q     <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   // Read data is only driven for a successful read; writes, errors and idle show zero.
   assign resp_rdata = rd_sel_q ? arr_rdata : 32'h0;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a timeline-based reference model and per-cycle compare.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int AW  = 12;
   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   state_t      dbg_state;

   dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit checking = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a request accepted at edge T responds after edge T+LAT,
   // commits at that edge, and retires at the first later edge with resp_ready.
   int          edge_cnt = 0;
   bit          m_pending = 0;
   bit          acc_flag = 0;
   int          m_acc = 0;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic        m_err = 1'b0;
   logic [31:0] m_rdata = 32'h0;
   bit          m_known = 1;
   logic [31:0] mem_m [int];

   always @(posedge clk) begin
      int          idx;
      logic [31:0] w;
      edge_cnt++;
      acc_flag = 0;
      if (rst) begin
         m_pending = 0;
      end else if (m_pending) begin
         if ((edge_cnt - 1 >= m_acc + LAT) && resp_ready) begin
            m_pending = 0;
         end else if (edge_cnt == m_acc + LAT) begin
            m_err   = (m_addr[1:0] != 2'b00) || (m_addr >= 32'(1 << AW));
            m_rdata = 32'h0;
            m_known = 1;
            if (!m_err) begin
               idx = int'(m_addr >> 2);
               if (m_we) begin
                  if (mem_m.exists(idx)) begin
                     w = mem_m[idx];
                     for (int b = 0; b < 4; b++)
                        if (m_be[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
                     mem_m[idx] = w;
                  end else if (m_be == 4'hF) begin
                     mem_m[idx] = m_wdata;
                  end
               end else if (mem_m.exists(idx)) begin
                  m_rdata = mem_m[idx];
               end else begin
                  m_known = 0;
               end
            end
         end
      end else if (req_valid) begin
         m_pending = 1;
         m_acc     = edge_cnt;
         m_we      = req_we;
         m_addr    = req_addr;
         m_wdata   = req_wdata;
         m_be      = req_be;
         acc_flag  = 1;
      end
   end

   bit          prev_v = 0;
   int          rise_edge = 0;
   logic [31:0] last_rdata = 32'h0;
   logic        last_err = 1'b0;

   always @(negedge clk) begin
      bit exp_v;
      if (checking) begin
         exp_v = m_pending && (edge_cnt >= m_acc + LAT);
         chk("req_ready", 32'(req_ready), 32'(!m_pending));
         chk("resp_valid", 32'(resp_valid), 32'(exp_v));
         if (exp_v) begin
            chk("resp_err", 32'(resp_err), 32'(m_err));
            if (m_known) chk("resp_rdata", resp_rdata, m_rdata);
         end
         if (resp_valid) begin
            if (!prev_v) rise_edge = edge_cnt;
            last_rdata = resp_rdata;
            last_err   = resp_err;
         end
         prev_v = resp_valid;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be);
      int n = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      req_be    = be;
      do begin
         step();
         n++;
      end while (!acc_flag && n < 50);
      chk("accept_timeout", 32'(acc_flag), 32'd1);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (m_pending && n < 200) begin
         step();
         n++;
      end
      chk("resp_timeout", 32'(m_pending), 32'd0);
   endtask

   task automatic read_expect(input string name, input logic [31:0] addr,
                              input logic [31:0] exp_d, input logic exp_e);
      send(1'b0, addr, 32'h0, 4'h0);
      wait_idle();
      chk({name, "_rdata"}, last_rdata, exp_d);
      chk({name, "_err"}, 32'(last_err), 32'(exp_e));
   endtask

   int a0;
   int a1;

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      req_be     = 4'h0;
      resp_ready = 1'b1;
      repeat (3) step();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      rst = 1'b0;
      checking = 1;

      repeat (10) begin
         step();
         chk("idle_rdata", resp_rdata, 32'h0);
      end

      // Full write, then back-to-back read: latency and throughput.
      send(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
      a0 = m_acc;
      wait_idle();
      chk("wr_latency", 32'(rise_edge - a0), 32'd4);
      chk("wr_rdata_zero", last_rdata, 32'h0);
      send(1'b0, 32'h100, 32'h0, 4'h0);
      a1 = m_acc;
      chk("b2b_spacing", 32'(a1 - a0), 32'd6);
      wait_idle();
      chk("rd_latency", 32'(rise_edge - a1), 32'd4);
      chk("rd100_rdata", last_rdata, 32'hDEADBEEF);
      chk("rd100_err", 32'(last_err), 32'd0);

      // Byte-lane merge.
      send(1'b1, 32'h100, 32'h000000AA, 4'b0001);
      wait_idle();
      read_expect("rd100_merge", 32'h100, 32'hDEADBEAA, 1'b0);

      // Misaligned and out-of-range accesses.
      read_expect("rd102", 32'h102, 32'h0, 1'b1);
      read_expect("rd2000", 32'h2000, 32'h0, 1'b1);
      send(1'b1, 32'h2100, 32'h11111111, 4'hF);
      wait_idle();
      chk("wr2100_err", 32'(last_err), 32'd1);
      send(1'b1, 32'h101, 32'h22222222, 4'hF);
      wait_idle();
      chk("wr101_err", 32'(last_err), 32'd1);
      send(1'b1, 32'h100, 32'hFFFFFFFF, 4'h0);
      wait_idle();
      chk("wr_be0_err", 32'(last_err), 32'd0);
      read_expect("rd100_unchanged", 32'h100, 32'hDEADBEAA, 1'b0);

      // Response stall for 7 cycles.
      resp_ready = 1'b0;
      send(1'b0, 32'h100, 32'h0, 4'h0);
      repeat (LAT) step();
      repeat (7) begin
         chk("stall_valid", 32'(resp_valid), 32'd1);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
         chk("stall_rdata", resp_rdata, 32'hDEADBEAA);
         chk("stall_err", 32'(resp_err), 32'd0);
         step();
      end
      resp_ready = 1'b1;
      step();
      chk("stall_release_valid", 32'(resp_valid), 32'd0);
      chk("stall_release_ready", 32'(req_ready), 32'd1);

      // Reset two cycles after accepting a write: the write must never land.
      send(1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
      wait_idle();
      send(1'b1, 32'h40, 32'h12345678, 4'hF);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      repeat (6) step();
      read_expect("rd40_after_rst", 32'h40, 32'hDEADBEEF, 1'b0);

      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog expired t=%0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
